// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
// Two-stage pipelined barrel shifter with a valid/ready handshake on both
// sides. Supports logical shift, arithmetic shift and rotate, selected per
// operation, with a signed shift amount (positive = left, negative = right).
//
// Stage 1 registers the operand and applies the low bits of the shift
// magnitude. Stage 2 applies the remaining high bits of the magnitude, then
// registers the result and the flags.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   in_valid   : operand on in_a/in_amt/in_mode is valid
//   in_ready   : block accepts the operand this cycle
//   in_a       : data to shift (WIDTH bits)
//   in_amt     : two's-complement shift amount (AW bits)
//   in_mode    : 00 logical, 01 arithmetic, 10 rotate, 11 reserved
//   out_valid  : result on out_* is valid
//   out_ready  : downstream takes the result this cycle
//   out_data   : shift result
//   out_carry  : last bit shifted out (rotate: bit that wrapped around)
//   out_zero   : out_data == 0
//   out_neg    : out_data[WIDTH-1]
//   out_err    : operation used the reserved mode
// -----------------------------------------------------------------------------
module shift_pipe #(
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_err
);

  // Split of the shift magnitude between the two stages.
  localparam int LO = AW / 2;
  localparam int HW = AW - LO;
  // The operand travels inside a double-width vector so that bits shifted
  // out of the result window are kept; the carry and the rotate wrap-around
  // are both recovered from that spill half.
  localparam int DW = 2 * WIDTH;

  localparam logic [1:0] MODE_LSH = 2'b00;
  localparam logic [1:0] MODE_ASH = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // Shift the extended vector by k; right shifts bring in the fill bit at
  // the top, left shifts always bring in zeros at the bottom.
  function automatic logic [DW-1:0] shift_ext(
    input logic [DW-1:0] v,
    input logic [AW-1:0] k,
    input logic          left,
    input logic          fill
  );
    logic [DW-1:0] fill_mask;
    if (left) begin
      fill_mask = {DW{1'b0}};
      return v << k;
    end else begin
      fill_mask = fill ? ~({DW{1'b1}} >> k) : {DW{1'b0}};
      return (v >> k) | fill_mask;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    vec_q, vec_d;
  logic [HW-1:0]    hi_q, hi_d;
  logic             left_q, left_d;
  logic             fill_q, fill_d;
  logic             sign_q, sign_d;
  logic             amt_zero_q, amt_zero_d;
  logic [1:0]       mode_q, mode_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             err_q, err_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s2_adv_s;
  logic s1_adv_s;
  logic accept_s;

  assign s2_adv_s = !s2_valid_q || out_ready;
  assign s1_adv_s = s1_valid_q && s2_adv_s;
  assign in_ready = !s1_valid_q || s2_adv_s;
  // Operands offered while reset is high are never taken.
  assign accept_s = in_valid && in_ready && !reset;

  // ---------------------------------------------------------------------------
  // Stage 1 datapath
  // ---------------------------------------------------------------------------
  logic             amt_neg_s;
  logic [AW-1:0]    mag_s;
  logic [AW-1:0]    sh_s;
  logic             left_s;
  logic             fill_s;
  logic [DW-1:0]    ext_s;
  logic [AW-1:0]    lo_amt_s;
  logic [DW-1:0]    vec1_s;

  assign amt_neg_s = in_amt[AW-1];
  // |amt| in AW bits: the most negative amount (-WIDTH) maps to WIDTH,
  // which is exactly representable as an unsigned AW-bit value.
  assign mag_s     = amt_neg_s ? ((~in_amt) + {{(AW-1){1'b0}}, 1'b1}) : in_amt;
  // Rotates use the magnitude mod WIDTH; since WIDTH is a power of two and
  // the magnitude never exceeds WIDTH, that is just the top bit dropped.
  assign sh_s      = (in_mode == MODE_ROT) ? {1'b0, mag_s[AW-2:0]} : mag_s;
  assign left_s    = !amt_neg_s;
  assign fill_s    = (in_mode == MODE_ASH) && amt_neg_s && in_a[WIDTH-1];
  // Left shifts spill into the upper half, right shifts into the lower half.
  assign ext_s     = left_s ? {{WIDTH{1'b0}}, in_a} : {in_a, {WIDTH{1'b0}}};
  assign lo_amt_s  = {{HW{1'b0}}, sh_s[LO-1:0]};
  assign vec1_s    = shift_ext(ext_s, lo_amt_s, left_s, fill_s);

  // ---------------------------------------------------------------------------
  // Stage 2 datapath
  // ---------------------------------------------------------------------------
  logic [AW-1:0]    hi_amt_s;
  logic [DW-1:0]    vec2_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             err_s;

  assign hi_amt_s = {hi_q, {LO{1'b0}}};
  assign vec2_s   = shift_ext(vec_q, hi_amt_s, left_q, fill_q);

  // Final result, carry and error selection from the fully shifted vector.
  always_comb begin
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    err_s   = 1'b0;
    if (left_q) begin
      res_s   = vec2_s[WIDTH-1:0];
      carry_s = vec2_s[WIDTH];
    end else begin
      res_s   = vec2_s[DW-1:WIDTH];
      carry_s = vec2_s[WIDTH-1];
    end
    case (mode_q)
      MODE_LSH: begin
        res_s = res_s;
      end
      MODE_ASH: begin
        // Arithmetic left keeps the original sign bit in place.
        if (left_q) begin
          res_s[WIDTH-1] = sign_q;
        end else begin
          res_s = res_s;
        end
      end
      MODE_ROT: begin
        // Fill is zero for rotates, so the spill half ORs in the wrapped bits.
        res_s   = vec2_s[WIDTH-1:0] | vec2_s[DW-1:WIDTH];
        carry_s = left_q ? res_s[0] : res_s[WIDTH-1];
      end
      MODE_RSV: begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        err_s   = 1'b1;
      end
      default: begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        err_s   = 1'b1;
      end
    endcase
    if (amt_zero_q) begin
      carry_s = 1'b0;
    end else begin
      carry_s = carry_s;
    end
  end

  // Next-state logic for both pipeline stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    vec_d      = vec_q;
    hi_d       = hi_q;
    left_d     = left_q;
    fill_d     = fill_q;
    sign_d     = sign_q;
    amt_zero_d = amt_zero_q;
    mode_d     = mode_q;
    s2_valid_d = s2_valid_q;
    data_d     = data_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    err_d      = err_q;

    if (accept_s) begin
      s1_valid_d = 1'b1;
      vec_d      = vec1_s;
      hi_d       = sh_s[AW-1:LO];
      left_d     = left_s;
      fill_d     = fill_s;
      sign_d     = in_a[WIDTH-1];
      amt_zero_d = (in_amt == {AW{1'b0}});
      mode_d     = in_mode;
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // Stage 2 only changes when it advances; while stalled with a valid
    // result everything it drives stays put.
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_d  = res_s;
        carry_d = carry_s;
        zero_d  = (res_s == {WIDTH{1'b0}});
        neg_d   = res_s[WIDTH-1];
        err_d   = err_s;
      end else begin
        data_d  = data_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      vec_q      <= {DW{1'b0}};
      hi_q       <= {HW{1'b0}};
      left_q     <= 1'b0;
      fill_q     <= 1'b0;
      sign_q     <= 1'b0;
      amt_zero_q <= 1'b0;
      mode_q     <= 2'b00;
      s2_valid_q <= 1'b0;
      data_q     <= {WIDTH{1'b0}};
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      vec_q      <= vec_d;
      hi_q       <= hi_d;
      left_q     <= left_d;
      fill_q     <= fill_d;
      sign_q     <= sign_d;
      amt_zero_q <= amt_zero_d;
      mode_q     <= mode_d;
      s2_valid_q <= s2_valid_d;
      data_q     <= data_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_zero  = zero_q;
  assign out_neg   = neg_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_pipe
// Scoreboard bench for shift_pipe (WIDTH=16). Expected results are computed
// by a bit-level reference model when an operand is accepted and compared
// in order when the DUT hands a result over.
// -----------------------------------------------------------------------------
module tb_shift_pipe;

  localparam int W  = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [AW-1:0] in_amt;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_carry;
  logic          out_zero;
  logic          out_neg;
  logic          out_err;

  shift_pipe #(.WIDTH(W), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    logic         zero;
    logic         neg;
    logic         err;
    int           acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t hold_e;
  int   n_checks = 0;
  int   n_bad    = 0;
  int   cyc      = 0;
  bit   lat_check     = 1'b0;
  bit   rand_ready_en = 1'b0;

  // Single comparison point: counts and reports mismatches.
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bit-level reference of the shift operations.
  function automatic exp_t model(input logic [W-1:0] a, input logic [AW-1:0] amt,
                                 input logic [1:0] mode);
    exp_t e;
    int   n;
    int   mag;
    int   k;
    n   = int'($signed(amt));
    mag = (n < 0) ? -n : n;
    e.data = a; e.carry = 1'b0; e.err = 1'b0; e.acc_cyc = 0;
    if (mode == 2'b11) begin
      e.data = '0;
      e.err  = 1'b1;
    end else if (n != 0) begin
      case (mode)
        2'b00: begin
          if (n > 0) begin e.data = a << n;   e.carry = a[W-n];   end
          else       begin e.data = a >> mag; e.carry = a[mag-1]; end
        end
        2'b01: begin
          if (n > 0) begin
            e.data = a << n; e.data[W-1] = a[W-1]; e.carry = a[W-n];
          end else begin
            e.data = $signed(a) >>> mag; e.carry = a[mag-1];
          end
        end
        default: begin
          k = mag % W;
          if (n > 0) e.data = (a << k) | (a >> (W - k));
          else       e.data = (a >> k) | (a << (W - k));
          e.carry = (n > 0) ? e.data[0] : e.data[W-1];
        end
      endcase
    end
    e.zero = (e.data == '0);
    e.neg  = e.data[W-1];
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_ready_en) out_ready <= ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: pop/compare on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check_eq("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check_eq("data",  out_data,  mon_e.data);
          check_eq("carry", out_carry, mon_e.carry);
          check_eq("zero",  out_zero,  mon_e.zero);
          check_eq("neg",   out_neg,   mon_e.neg);
          check_eq("err",   out_err,   mon_e.err);
          if (lat_check) check_eq("latency", cyc - mon_e.acc_cyc, 2);
        end
      end
      if (in_valid && in_ready) begin
        mon_e = model(in_a, in_amt, in_mode);
        mon_e.acc_cyc = cyc;
        sb_q.push_back(mon_e);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one operand until accepted; called at posedge+1.
  task automatic send(input logic [W-1:0] a, input logic [AW-1:0] amt, input logic [1:0] mode,
                      input bit expect_now);
    int guard;
    bit acc;
    guard = 0;
    in_valid = 1'b1; in_a = a; in_amt = amt; in_mode = mode;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 2000);
    check_eq("send_accept", acc, 1);
    if (expect_now) check_eq("throughput", guard, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 500) begin @(posedge clk); #1; g++; end
    check_eq("drain", sb_q.size(), 0);
  endtask

  logic [W-1:0]  dir_a   [12] = '{16'h8001, 16'h8001, 16'h8001, 16'h8000, 16'hC001, 16'h8000,
                                  16'h8001, 16'h8001, 16'h8001, 16'h1234, 16'h00F0, 16'h4001};
  logic [AW-1:0] dir_amt [12] = '{5'sd1, -5'sd1, -5'sd16, -5'sd4, 5'sd1, -5'sd16,
                                  5'sd1, -5'sd16, 5'sd3, 5'sd4, 5'sd0, 5'sd15};
  logic [1:0]    dir_md  [12] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01,
                                  2'b10, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01};

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_amt = '0; in_mode = 2'b00; out_ready = 1'b1;
    wait_cycles(2);
    // Operand offered during reset must be ignored.
    in_valid = 1'b1; in_a = 16'h1234; in_amt = 5'd1;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data",  out_data,  0);
    check_eq("rst_flags", {out_carry, out_zero, out_neg, out_err}, 0);
    check_eq("rst_in_ready",  in_ready,  1);
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b0;
    repeat (3) begin @(negedge clk); check_eq("post_rst_idle", out_valid, 0); end
    @(posedge clk); #1;

    // Directed vectors, full throughput, 2-cycle latency.
    lat_check = 1'b1;
    for (int i = 0; i < 12; i++) send(dir_a[i], dir_amt[i], dir_md[i], 1'b1);
    wait_cycles(3);
    drain();
    lat_check = 1'b0;

    // Backpressure: two accepted, third stalls, first result held.
    out_ready = 1'b0;
    hold_e = model(16'h0F0F, 5'sd2, 2'b00);
    in_valid = 1'b1; in_a = 16'h0F0F; in_amt = 5'sd2; in_mode = 2'b00;
    @(negedge clk); check_eq("bp_acc0", in_ready, 1);
    @(posedge clk); #1;
    in_a = 16'h8421; in_amt = -5'sd3; in_mode = 2'b01;
    @(negedge clk); check_eq("bp_acc1", in_ready, 1);
    @(posedge clk); #1;
    in_a = 16'h1357; in_amt = 5'sd5; in_mode = 2'b10;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_hold_data", out_data, hold_e.data);
      check_eq("bp_hold_carry", out_carry, hold_e.carry);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(16'h1357, 5'sd5, 2'b10, 1'b0);
    send(16'hA5A5, -5'sd7, 2'b11, 1'b0);
    drain();

    // Reset with both stages full discards them.
    out_ready = 1'b0;
    send(16'hFFFF, 5'sd3, 2'b00, 1'b0);
    send(16'h00FF, -5'sd2, 2'b01, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) begin @(negedge clk); check_eq("no_stale", out_valid, 0); end
    @(posedge clk); #1;
    lat_check = 1'b1;
    send(16'h0180, -5'sd8, 2'b10, 1'b1);
    wait_cycles(3);
    drain();
    lat_check = 1'b0;

    // Random sweep with random downstream readiness.
    rand_ready_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      send(W'($urandom), AW'($urandom), 2'($urandom_range(0, 3)), 1'b0);
      if ($urandom_range(0, 7) == 0) wait_cycles(1);
    end
    rand_ready_en = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
